pe_command_sequencer: RTL and testbench

//  Upstream controller for the message_passer PE array. Issues the per-run command stream over the shared
//  ack/ready handshake: clear, operand load, then N MAC/shift-left-B/shift-up-A rounds (final MAC, no shift).

---
 rtl/pe_command_sequencer_pkg.sv | 24 ++
 rtl/pe_seq_step_decode.sv | 38 +++
 rtl/pe_command_sequencer.sv | 129 ++++++++++++
 tb/tb_pe_command_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_command_sequencer_pkg.sv
// rtl/pe_command_sequencer_pkg.sv - PE opcodes, image select codes and sequencer FSM states
package pe_command_sequencer_pkg;

  localparam logic [2:0] CMD_MAC      = 3'b000;
  localparam logic [2:0] CMD_UP       = 3'b001;
  localparam logic [2:0] CMD_DOWN     = 3'b010;
  localparam logic [2:0] CMD_LEFT     = 3'b011;
  localparam logic [2:0] CMD_RIGHT    = 3'b100;
  localparam logic [2:0] CMD_OVR_AB   = 3'b101;
  localparam logic [2:0] CMD_OVR_SOUT = 3'b110;
  localparam logic [2:0] CMD_CLEAR    = 3'b111;

  localparam logic IMG_A = 1'b0;
  localparam logic IMG_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACK_HI = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pe_seq_step_decode.sv
// rtl/pe_seq_step_decode.sv - combinational map from command index to {opcode, image, last}
module pe_seq_step_decode
  import pe_command_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(3*N+1)
) (
  input  logic [SW-1:0] i_step,
  output logic [2:0]    o_cmd,
  output logic          o_img,
  output logic          o_last
);

  logic [SW-1:0] w_rel;
  logic [SW-1:0] w_phase;

  // After clear and operand load, each round is MAC, shift B left, shift A up.
  assign w_rel   = i_step - SW'(2);
  assign w_phase = w_rel % SW'(3);
  assign o_last  = (i_step == SW'(3*N-1));

  always_comb begin
    o_cmd = CMD_MAC;
    o_img = IMG_A;
    if (i_step == '0) begin
      o_cmd = CMD_CLEAR;
    end else if (i_step == SW'(1)) begin
      o_cmd = CMD_OVR_AB;
    end else if (w_phase == SW'(1)) begin
      o_cmd = CMD_LEFT;
      o_img = IMG_B;
    end else if (w_phase == SW'(2)) begin
      o_cmd = CMD_UP;
      o_img = IMG_A;
    end
  end

endmodule

// File: rtl/pe_command_sequencer.sv
// rtl/pe_command_sequencer.sv - issues the clear/load/MAC-shift command stream to the PE array
// Optional ISSUE watchdog with sticky err: define PE_SEQ_TIMEOUT_EN.
module pe_command_sequencer
  import pe_command_sequencer_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  localparam int SW     = $clog2(3*N+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_ready_all,
  output logic          o_ack,
  output logic [2:0]    o_command_to_execute,
  output logic          o_image_to_shift,
  output logic          o_busy,
  output logic          o_done,
  output logic [SW-1:0] o_step,
  output logic          o_err
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [SW-1:0] r_step;
  logic [2:0]    r_cmd;
  logic          r_img;
  logic [2:0]    w_dec_cmd;
  logic          w_dec_img;
  logic          w_dec_last;
  logic          w_timeout;
  logic          w_start_acc;

  pe_seq_step_decode #(
    .N  (N),
    .SW (SW)
  ) u_decode (
    .i_step (r_step),
    .o_cmd  (w_dec_cmd),
    .o_img  (w_dec_img),
    .o_last (w_dec_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_ack  = 1'b1;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_ACK_HI: o_busy = 1'b1;
      ST_ISSUE: begin
        o_ack  = 1'b0;
        o_busy = 1'b1;
      end
      ST_DONE:   o_done = 1'b1;
      default: ;
    endcase
    // Abort overrides everything, including a start in the same cycle.
    if (i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR: if (i_start) w_next = ST_ACK_HI;
        ST_ACK_HI:       if (!i_ready_all) w_next = ST_ISSUE;
        ST_ISSUE: begin
          if (i_ready_all) w_next = w_dec_last ? ST_DONE : ST_ACK_HI;
          else if (w_timeout) w_next = ST_ERR;
        end
        ST_DONE:         w_next = ST_IDLE;
        default:         w_next = ST_IDLE;
      endcase
    end
  end

  assign w_start_acc = (w_next == ST_ACK_HI) && ((r_state == ST_IDLE) || (r_state == ST_ERR));

  // Opcode/image only move on the ACK_HI->ISSUE edge so the PEs never see a change with ack low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step <= '0;
      r_cmd  <= CMD_MAC;
      r_img  <= IMG_A;
    end else begin
      if (w_start_acc) r_step <= '0;
      else if ((r_state == ST_ISSUE) && (w_next == ST_ACK_HI)) r_step <= r_step + 1'b1;
      if ((r_state == ST_ACK_HI) && (w_next == ST_ISSUE)) begin
        r_cmd <= w_dec_cmd;
        r_img <= w_dec_img;
      end
    end
  end

  assign o_command_to_execute = r_cmd;
  assign o_image_to_shift     = r_img;
  assign o_step               = r_step;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;

  logic [WDW-1:0] r_wd;
  logic           r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_wd <= '0;
    else if (r_state == ST_ISSUE) r_wd <= r_wd + 1'b1;
    else                         r_wd <= '0;
  end

  assign w_timeout = (r_wd == WDW'(TIMEOUT-1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_err <= 1'b0;
    else if (w_next == ST_ERR)  r_err <= 1'b1;
    else if (w_start_acc)       r_err <= 1'b0;
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pe_command_sequencer.sv
// tb/tb_pe_command_sequencer.sv - directed self-checking bench for pe_command_sequencer
module tb_pe_command_sequencer;
  localparam int N  = 4;
  localparam int SW = $clog2(3*N+1);

  logic          clk = 1'b0;
  logic          rst, start, abort, ready_all;
  logic          ack, img, busy, done, err;
  logic [2:0]    cmd;
  logic [SW-1:0] step;
  logic          pe_hold;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  // Zero-wait PE array: ready mirrors ~ack unless the bench holds it low.
  assign ready_all = pe_hold ? 1'b0 : ~ack;

  pe_command_sequencer #(.N(N), .TIMEOUT(64)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_start              (start),
    .i_abort              (abort),
    .i_ready_all          (ready_all),
    .o_ack                (ack),
    .o_command_to_execute (cmd),
    .o_image_to_shift     (img),
    .o_busy               (busy),
    .o_done               (done),
    .o_step               (step),
    .o_err                (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pe_hold = 1'b0;
    #12;
    checks++; if (ack !== 1'b1)    begin failures++; $display("FAIL reset_ack got=%b exp=1", ack); end
    checks++; if (cmd !== 3'b000)  begin failures++; $display("FAIL reset_cmd got=%b exp=000", cmd); end
    checks++; if (img !== 1'b0)    begin failures++; $display("FAIL reset_img got=%b exp=0", img); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (step !== '0)     begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_full_run;
    logic [2:0] exp_cmd [12];
    logic       exp_img [12];
    logic       prev_ack, prev_ready, prev_img;
    logic [2:0] prev_cmd;
    int         idx, done_cnt, done_at;
    exp_cmd = '{3'b111, 3'b101, 3'b000, 3'b011, 3'b001, 3'b000,
                3'b011, 3'b001, 3'b000, 3'b011, 3'b001, 3'b000};
    exp_img = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    idx = 0; done_cnt = 0; done_at = -1;
    start = 1'b1; tick; start = 1'b0;
    prev_ack = ack; prev_ready = ready_all; prev_cmd = cmd; prev_img = img;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (n == 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy_early got=%b exp=1", busy); end
      end
      if (n == 24) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy_done got=%b exp=0", busy); end
      end
      if (prev_ack == 1'b0 && ack == 1'b0) begin
        checks++;
        if (cmd !== prev_cmd || img !== prev_img) begin
          failures++; $display("FAIL proto_stable n=%0d cmd=%b/%b img=%b/%b", n, cmd, prev_cmd, img, prev_img);
        end
      end
      if (prev_ack == 1'b1 && ack == 1'b0) begin
        checks++; if (prev_ready !== 1'b0) begin failures++; $display("FAIL proto_ready n=%0d got=%b exp=0", n, prev_ready); end
        if (idx < 12) begin
          checks++;
          if (cmd !== exp_cmd[idx] || img !== exp_img[idx] || step !== SW'(idx)) begin
            failures++;
            $display("FAIL cmd_seq idx=%0d cmd=%b exp=%b img=%b exp=%b step=%0d exp=%0d",
                     idx, cmd, exp_cmd[idx], img, exp_img[idx], step, idx);
          end
        end
        idx++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      prev_ack = ack; prev_ready = ready_all; prev_cmd = cmd; prev_img = img;
    end
    checks++; if (idx != 12) begin failures++; $display("FAIL cmd_count got=%0d exp=12", idx); end
    checks++;
    if (done_cnt != 1 || done_at != 24) begin
      failures++; $display("FAIL done_pulse count=%0d exp=1 cycle=%0d exp=24", done_cnt, done_at);
    end
    checks++;
    if (busy !== 1'b0 || ack !== 1'b1 || step !== SW'(3*N-1)) begin
      failures++; $display("FAIL run_end busy=%b ack=%b step=%0d exp 0/1/%0d", busy, ack, step, 3*N-1);
    end
  endtask

  task automatic test_stall;
    bit found, seen;
    found = 1'b0; seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (ack == 1'b0 && step == SW'(4)) found = 1'b1;
      else tick;
    end
    checks++; if (!found) begin failures++; $display("FAIL stall_reach step=%0d exp=4", step); end
    pe_hold = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      start = 1'b0;
      checks++;
      if (ack !== 1'b0 || cmd !== 3'b001 || img !== 1'b0 || step !== SW'(4) || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold i=%0d ack=%b cmd=%b img=%b step=%0d busy=%b exp 0/001/0/4/1", i, ack, cmd, img, step, busy);
      end
    end
    pe_hold = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_done got=0 exp=1"); end
    tick;
  endtask

  task automatic test_abort;
    bit found, seen;
    found = 1'b0; seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (step == SW'(5)) found = 1'b1;
      else tick;
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_reach step=%0d exp=5", step); end
    abort = 1'b1; tick; abort = 1'b0;
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd !== 3'b001 || img !== 1'b0) begin
      failures++; $display("FAIL abort_idle ack=%b busy=%b done=%b cmd=%b img=%b exp 1/0/0/001/0", ack, busy, done, cmd, img);
    end
    for (int n = 0; n < 6; n++) begin
      tick;
      if (done === 1'b1 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL abort_quiet got=1 exp=0"); end
    start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b1) begin
      failures++; $display("FAIL abort_wins busy=%b ack=%b exp 0/1", busy, ack);
    end
    found = 1'b0; seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (ack == 1'b0) found = 1'b1;
      else tick;
    end
    checks++;
    if (!found || step !== '0 || cmd !== 3'b111) begin
      failures++; $display("FAIL abort_restart issue=%b step=%0d cmd=%b exp 1/0/111", found, step, cmd);
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_rerun_done got=0 exp=1"); end
    tick;
  endtask

  task automatic test_async_reset;
    bit found, seen;
    found = 1'b0; seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (ack == 1'b0 && step == SW'(3)) found = 1'b1;
      else tick;
    end
    checks++;
    if (!found || cmd !== 3'b011 || img !== 1'b1) begin
      failures++; $display("FAIL rst_setup issue=%b cmd=%b img=%b exp 1/011/1", found, cmd, img);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b1 || cmd !== 3'b000 || img !== 1'b0 || busy !== 1'b0 || step !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_async ack=%b cmd=%b img=%b busy=%b step=%0d done=%b exp 1/000/0/0/0/0", ack, cmd, img, busy, step, done);
    end
    #2 rst = 1'b0;
    tick;
    found = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (ack == 1'b0) found = 1'b1;
      else tick;
    end
    checks++;
    if (!found || step !== '0 || cmd !== 3'b111) begin
      failures++; $display("FAIL rst_resume issue=%b step=%0d cmd=%b exp 1/0/111", found, step, cmd);
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_resume_done got=0 exp=1"); end
    tick;
  endtask

  task automatic test_timeout;
    bit found, seen;
    found = 1'b0; seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (ack == 1'b0) found = 1'b1;
      else tick;
    end
    checks++; if (!found) begin failures++; $display("FAIL to_reach ack=%b exp=0", ack); end
    pe_hold = 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
    for (int i = 0; i < 63; i++) tick;
    checks++;
    if (err !== 1'b0 || ack !== 1'b0) begin
      failures++; $display("FAIL to_early err=%b ack=%b exp 0/0", err, ack);
    end
    tick;
    checks++;
    if (err !== 1'b1 || ack !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL to_fire err=%b ack=%b busy=%b done=%b exp 1/1/0/0", err, ack, busy, done);
    end
    tick; tick;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", err); end
    pe_hold = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || step !== '0) begin
      failures++; $display("FAIL to_restart err=%b busy=%b step=%0d exp 0/1/0", err, busy, step);
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_rerun_done got=0 exp=1"); end
`else
    for (int i = 0; i < 100; i++) tick;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b1 || err !== 1'b0 || step !== '0 || cmd !== 3'b111) begin
      failures++;
      $display("FAIL to_hang ack=%b busy=%b err=%b step=%0d cmd=%b exp 0/1/0/0/111", ack, busy, err, step, cmd);
    end
    abort = 1'b1; tick; abort = 1'b0;
    pe_hold = 1'b0;
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL to_abort ack=%b busy=%b err=%b exp 1/0/0", ack, busy, err);
    end
`endif
    tick;
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_stall;
    test_abort;
    test_async_reset;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "bench time limit");
  end

endmodule
